// File: rtl/aes_dec_pkg.sv
// AES decipher shared types, round counts and GF(2^8) helpers (poly 0x11b).
// aes_block_t holds FIPS-197 byte n at index [15-n], so byte 0 is bits [127:120].
package aes_dec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SUB,
    ST_MIX,
    ST_DONE
  } dec_state_e;

  typedef logic [15:0][7:0] aes_block_t;

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] x);
    return gm2(gm2(x));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] x);
    return gm2(gm4(x));
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] x);
    return gm8(x) ^ x;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] x);
    return gm8(x) ^ gm2(x) ^ x;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] x);
    return gm8(x) ^ gm4(x) ^ x;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] x);
    return gm8(x) ^ gm4(x) ^ gm2(x);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gm2(p);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] acc;
    logic [7:0] sq;
    acc = 8'h01;
    sq  = x;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Row r is rotated right by r columns.
  function automatic aes_block_t inv_shift_rows(input aes_block_t s);
    aes_block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4'(15 - 4*c - r)] = s[4'(15 - 4*((c + 4 - r) % 4) - r)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn.sv
// AES InvMixColumns on one 32-bit column (row 0 in bits [31:24]).
// Combinational, zero latency, no flow control.
module aes_inv_mixcolumn (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  import aes_dec_pkg::*;

  logic [7:0] a0, a1, a2, a3;

  assign {a0, a1, a2, a3} = col;

  assign mixed = {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm09(a3),
                  gm09(a0) ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                  gm13(a0) ^ gm09(a1) ^ gm14(a2) ^ gm11(a3),
                  gm11(a0) ^ gm13(a1) ^ gm09(a2) ^ gm14(a3)};

endmodule

// File: rtl/aes_inv_sbox.sv
// AES inverse S-box: inverse affine transform followed by GF(2^8) inversion.
// Combinational, zero latency, no flow control.
module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  import aes_dec_pkg::*;

  logic [7:0] pre;

  assign pre = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  assign y   = gf_inv(pre);

endmodule

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher, 1 + Nr*(16/SBOX_LANES + 1) cycles accept-to-result_valid;
// result held until result_ready, ready only in IDLE. Define AES_DEC_KEY256_EN for AES-256.
module aes_inv_round_engine #(
  parameter int SBOX_LANES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         keylen,
  input  logic         start,
  output logic         ready,
  input  logic [127:0] block,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic [127:0] result,
  output logic         result_valid,
  input  logic         result_ready
);
  import aes_dec_pkg::*;

  localparam int GROUPS = 16 / SBOX_LANES;
  localparam int LCW    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [LCW-1:0] LANE_LAST = LCW'(GROUPS - 1);

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_round_engine: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  dec_state_e     state_q, state_d;
  aes_block_t     st_q, st_d, sub_st, inv_t, mix_st;
  logic [3:0]     ridx_d, nr_sel, grp_base;
  logic [127:0]   res_d;
  logic [LCW-1:0] lane_q, lane_d;
  logic [7:0]     sb_in  [SBOX_LANES];
  logic [7:0]     sb_out [SBOX_LANES];

`ifdef AES_DEC_KEY256_EN
  assign nr_sel = keylen ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);
`else
  logic keylen_unused;
  assign keylen_unused = keylen;
  assign nr_sel        = 4'(AES128_ROUNDS);
`endif

  // Each SUB cycle the lane counter selects one group of SBOX_LANES bytes.
  assign grp_base = 4'(int'(lane_q) * SBOX_LANES);

  always_comb begin
    for (int l = 0; l < SBOX_LANES; l++) begin
      sb_in[l] = st_q[4'(15) - grp_base - 4'(l)];
    end
  end

  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .x (sb_in[l]),
      .y (sb_out[l])
    );
  end

  always_comb begin
    sub_st = st_q;
    for (int l = 0; l < SBOX_LANES; l++) begin
      sub_st[4'(15) - grp_base - 4'(l)] = sb_out[l];
    end
  end

  // InvSubBytes already happened in SUB; the two steps commute.
  assign inv_t = inv_shift_rows(st_q) ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_inv_mixcolumn u_mix (
      .col   (inv_t[15-4*c -: 4]),
      .mixed (mix_st[15-4*c -: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    ridx_d  = round_idx;
    lane_d  = lane_q;
    res_d   = result;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          st_d    = block;
          ridx_d  = nr_sel;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        st_d    = st_q ^ round_key;
        ridx_d  = round_idx - 4'd1;
        lane_d  = '0;
        state_d = ST_SUB;
      end
      ST_SUB: begin
        st_d = sub_st;
        if (lane_q == LANE_LAST) begin
          lane_d  = '0;
          state_d = ST_MIX;
        end else begin
          lane_d = lane_q + LCW'(1);
        end
      end
      ST_MIX: begin
        if (round_idx != 4'd0) begin
          st_d    = mix_st;
          ridx_d  = round_idx - 4'd1;
          state_d = ST_SUB;
        end else begin
          res_d   = inv_t;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= '0;
      round_idx <= '0;
      lane_q    <= '0;
      result    <= '0;
    end else begin
      st_q      <= st_d;
      round_idx <= ridx_d;
      lane_q    <= lane_d;
      result    <= res_d;
    end
  end

  assign ready        = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);

endmodule
